imem_line_responder: RTL and testbench

- Responder end of the instruction-fetch memory port: accepts fetch requests (imem_addr/imem_rmask) from the fetch stage and returns imem_rdata with a one-cycle imem_resp pulse.
- Holds one instruction line in a single-entry line buffer. On a miss it refills the line from burst memory (bmem), in LINE_BEATS beats of BMEM_DATA_W bits.
- Sits between the fetch stage and the memory arbiter/bmem model.

---
 rtl/imem_line_responder_pkg.sv | 20 ++
 rtl/imem_line_responder_fill.sv | 56 +++++
 rtl/imem_line_responder.sv | 181 ++++++++++++++++++
 tb/tb_imem_line_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_line_responder_pkg.sv
// Shared types for the instruction-fetch line responder.
//   imem_resp_state_t : responder FSM states
//   IMEM_LINE_W       : line width in bits (32 bytes)
//   IMEM_OFFSET_W     : byte-offset bits inside one line
//   imem_line_t       : one full instruction line
//   line_word()       : selects 32-bit word idx from a line
package rv32i_types;

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} imem_resp_state_t;

  localparam int unsigned IMEM_LINE_W   = 256;
  localparam int unsigned IMEM_OFFSET_W = 5;

  typedef logic [IMEM_LINE_W-1:0] imem_line_t;

  function automatic logic [31:0] line_word(input imem_line_t line, input logic [2:0] idx);
    return line[idx*32 +: 32];
  endfunction

endpackage

// File: rtl/imem_line_responder_fill.sv
// Line assembly for the instruction line responder: beat counter plus line register.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : restart assembly at beat 0 (burst accepted)
//   beat_valid_i  : accept beat_data_i into the slot selected by the counter
//   beat_data_i   : one burst beat
//   line_o        : assembled line (registered)
//   fill_done_o   : pulses with the beat that completes the line
module imem_line_fill
  import rv32i_types::*;
#(
  parameter int unsigned BMEM_DATA_W = 64,
  parameter int unsigned LINE_BEATS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   beat_valid_i,
  input  logic [BMEM_DATA_W-1:0] beat_data_i,
  output logic [IMEM_LINE_W-1:0] line_o,
  output logic                   fill_done_o
);

  localparam int unsigned CntW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  imem_line_t      line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (beat_valid_i) begin
      line_d[cnt_q*BMEM_DATA_W +: BMEM_DATA_W] = beat_data_i;
      // Hold on the last beat; only the next burst's clear rewinds the counter.
      if (cnt_q != LastBeat) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_o      = line_q;
  assign fill_done_o = beat_valid_i && !clear_i && (cnt_q == LastBeat);

endmodule

// File: rtl/imem_line_responder.sv
// Instruction-fetch responder with a single-entry line buffer refilled from burst memory.
//   clk, rst                 : clock, synchronous active-high reset
//   imem_addr, imem_rmask    : fetch request (valid when rmask != 0), held until imem_resp
//   imem_rdata, imem_resp    : fetched word and its one-cycle response pulse
//   bmem_addr, bmem_read     : line-aligned burst request, held until bmem_ready
//   bmem_ready               : burst request accepted
//   bmem_raddr/rdata/rvalid  : returning beats, tagged with their line address
// Optional macro IMEM_PERF_CNT_EN adds saturating hit_count / miss_count outputs.
module imem_line_responder
  import rv32i_types::*;
#(
  parameter int unsigned BMEM_DATA_W = 64,
  parameter int unsigned LINE_BEATS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            imem_addr,
  input  logic [3:0]             imem_rmask,
  output logic [31:0]            imem_rdata,
  output logic                   imem_resp,
  output logic [31:0]            bmem_addr,
  output logic                   bmem_read,
  input  logic                   bmem_ready,
  input  logic [31:0]            bmem_raddr,
  input  logic [BMEM_DATA_W-1:0] bmem_rdata,
  input  logic                   bmem_rvalid
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);

  localparam int unsigned TagW = 32 - IMEM_OFFSET_W;

  imem_resp_state_t  state_q, state_d;
  logic              line_valid_q, line_valid_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic [2:0]        word_q, word_d;
  logic              resp_q, resp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bmem_read_q, bmem_read_d;
  logic [31:0]       bmem_addr_q, bmem_addr_d;

  imem_line_t        line;
  imem_line_t        line_last;
  logic              req_valid, req_hit, fill_clear, beat_valid, fill_done;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^imem_addr[1:0];

  assign req_valid  = |imem_rmask;
  assign req_hit    = line_valid_q && (tag_q == imem_addr[31:IMEM_OFFSET_W]);
  assign fill_clear = (state_q == REQ) && bmem_ready;
  // bmem_addr_q keeps the line base for the whole fill, so it doubles as the beat filter.
  assign beat_valid = (state_q == FILL) && bmem_rvalid && (bmem_raddr == bmem_addr_q);

  imem_line_fill #(
    .BMEM_DATA_W (BMEM_DATA_W),
    .LINE_BEATS  (LINE_BEATS)
  ) u_fill (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (fill_clear),
    .beat_valid_i (beat_valid),
    .beat_data_i  (bmem_rdata),
    .line_o       (line),
    .fill_done_o  (fill_done)
  );

  // Line as it will look once the completing beat lands; lets RESP present the word
  // in the cycle right after the last beat.
  always_comb begin
    line_last = line;
    line_last[(LINE_BEATS-1)*BMEM_DATA_W +: BMEM_DATA_W] = bmem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    word_d       = word_q;
    resp_d       = 1'b0;
    rdata_d      = rdata_q;
    bmem_read_d  = bmem_read_q;
    bmem_addr_d  = bmem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_hit) begin
            resp_d  = 1'b1;
            rdata_d = line_word(line, imem_addr[IMEM_OFFSET_W-1:2]);
          end else begin
            word_d       = imem_addr[IMEM_OFFSET_W-1:2];
            bmem_addr_d  = {imem_addr[31:IMEM_OFFSET_W], {IMEM_OFFSET_W{1'b0}}};
            bmem_read_d  = 1'b1;
            // The refill overwrites the buffer in place, so the old line is gone.
            line_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (bmem_ready) begin
          bmem_read_d = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (fill_done) begin
          line_valid_d = 1'b1;
          tag_d        = bmem_addr_q[31:IMEM_OFFSET_W];
          resp_d       = 1'b1;
          rdata_d      = line_word(line_last, word_q);
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      word_q       <= '0;
      resp_q       <= 1'b0;
      rdata_q      <= '0;
      bmem_read_q  <= 1'b0;
      bmem_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      word_q       <= word_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      bmem_read_q  <= bmem_read_d;
      bmem_addr_q  <= bmem_addr_d;
    end
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_addr  = bmem_addr_q;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && req_valid) begin
      if (req_hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// Randomized scoreboard bench for imem_line_responder. Memory contents are a pure function
// of address; the reference model only tracks which line is resident.
module tb_imem_line_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  imem_line_responder dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
`ifdef IMEM_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];
  logic [31:0] burst_q[$];
  int          n_hs = 0;
  int          n_hs_exp = 0;
  int          beats_sent = 0;
  bit          perturb_en = 1'b0;
  bit          model_valid = 1'b0;
  logic [26:0] model_tag = '0;
  bit          after_miss = 1'b0;
  int          exp_hits = 0;
  int          exp_misses = 0;

  function automatic logic [63:0] mem_beat(input logic [31:0] base, input int beat);
    logic [31:0] b;
    b = 32'(beat);
    if (base == 32'h1eceb000 && beat == 0) return 64'h00000013_00100093;
    return {base ^ 32'h9e3779b9 ^ b, base + 32'h01010101 * (b + 32'd1)};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [63:0] b;
    b = mem_beat({addr[31:5], 5'b0}, int'(addr[4:3]));
    return addr[2] ? b[63:32] : b[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_imem_resp"}, 32'(imem_resp), 32'd0);
    check({tag, "_imem_rdata"}, imem_rdata, 32'd0);
    check({tag, "_bmem_read"}, 32'(bmem_read), 32'd0);
    check({tag, "_bmem_addr"}, bmem_addr, 32'd0);
`ifdef IMEM_PERF_CNT_EN
    check({tag, "_hit_count"}, hit_count, 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  // Monitor: every response pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && imem_resp === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h, expected no response", imem_rdata);
      end else begin
        check("rdata", imem_rdata, sb_q.pop_front());
      end
    end
  end

  // Burst memory: random accept delay, random gaps and foreign-address beats.
  initial begin : bmem_model
    logic [31:0] base;
    logic [31:0] sv_addr;
    logic [3:0]  sv_mask;
    int          beat;
    int          cyc;
    bit          pert;
    bit          seen;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    seen        = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      if (rst) begin
        seen = 1'b0;
        continue;
      end
      if (bmem_read !== 1'b1) continue;
      if (!seen) begin
        seen = 1'b1;
        if (burst_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_burst: got bmem_read at %h, expected none", bmem_addr);
        end else begin
          check("burst_addr", bmem_addr, burst_q.pop_front());
        end
      end
      if ($urandom_range(0, 1) == 0) continue;
      base       = bmem_addr;
      bmem_ready = 1'b1;
      // A beat alongside the accept must be ignored by the DUT.
      if ($urandom_range(0, 2) == 0) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = base;
        bmem_rdata  = ~mem_beat(base, 0);
      end
      @(posedge clk);
      #1;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      seen        = 1'b0;
      if (rst) continue;
      n_hs++;
      pert = perturb_en && ($urandom_range(0, 2) == 0);
      beat = 0;
      cyc  = 0;
      while (beat < 4) begin
        if (rst) break;
        if (pert && cyc == 0) begin
          sv_addr    = imem_addr;
          sv_mask    = imem_rmask;
          imem_addr  = $urandom;
          imem_rmask = 4'hf;
        end else if (pert && cyc == 1) begin
          imem_addr  = sv_addr;
          imem_rmask = sv_mask;
        end
        case ($urandom_range(0, 3))
          0: bmem_rvalid = 1'b0;
          1: begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0;
            bmem_rdata  = {$urandom, $urandom};
          end
          default: begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = base;
            bmem_rdata  = mem_beat(base, beat);
            beat++;
            beats_sent++;
          end
        endcase
        @(posedge clk);
        #1;
        bmem_rvalid = 1'b0;
        cyc++;
      end
    end
  end

  task automatic do_req(input logic [31:0] addr);
    bit hit;
    int cyc;
    int exp_lat;
    hit = model_valid && (model_tag == addr[31:5]);
    sb_q.push_back(mem_word(addr));
    if (hit) begin
      exp_hits++;
    end else begin
      exp_misses++;
      burst_q.push_back({addr[31:5], 5'b0});
      n_hs_exp++;
      model_valid = 1'b1;
      model_tag   = addr[31:5];
    end
    // A request presented during the miss response cycle waits one extra cycle.
    exp_lat    = after_miss ? 2 : 1;
    imem_addr  = addr;
    imem_rmask = 4'($urandom_range(1, 15));
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (imem_resp === 1'b1) break;
      if (cyc >= 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_timeout: got no resp for %h after %0d cycles, expected one", addr,
                 cyc);
        break;
      end
    end
    if (hit) begin
      check("hit_latency", 32'(cyc), 32'(exp_lat));
    end else begin
      n_cmp++;
      if (cyc < 6) begin
        n_fail++;
        $display("FAIL miss_latency: got %0d cycles for %h, expected at least 6", cyc, addr);
      end
    end
    after_miss = !hit;
  endtask

  task automatic idle(input int n);
    imem_rmask = 4'h0;
    imem_addr  = $urandom;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    after_miss = 1'b0;
  endtask

  task automatic reset_mid_fill(input logic [31:0] addr);
    int cyc;
    burst_q.push_back({addr[31:5], 5'b0});
    n_hs_exp++;
    beats_sent = 0;
    imem_addr  = addr;
    imem_rmask = 4'hf;
    cyc = 0;
    while (beats_sent < 2 && cyc < 300) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("beats_before_reset", 32'(beats_sent >= 2), 32'd1);
    @(posedge clk);
    #2;
    rst        = 1'b1;
    imem_rmask = 4'h0;
    @(posedge clk);
    #1;
    check_reset_vals("mid_fill");
    @(posedge clk);
    #1;
    rst = 1'b0;
    burst_q.delete();
    model_valid = 1'b0;
    after_miss  = 1'b0;
    exp_hits    = 0;
    exp_misses  = 0;
  endtask

  logic [31:0] bases[3] = '{32'h1eceb000, 32'h1eceb020, 32'h80000100};

  initial begin : main
    logic [31:0] a;
    imem_addr  = '0;
    imem_rmask = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;

    do_req(32'h1eceb000);
    do_req(32'h1eceb004);
    do_req(32'h1eceb01c);
    do_req(32'h1eceb020);

    idle(8);
    check("idle_bmem_read", 32'(bmem_read), 32'd0);
    check("idle_imem_resp", 32'(imem_resp), 32'd0);

    reset_mid_fill(32'h1eceb000);
    do_req(32'h1eceb000);

    perturb_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      a = bases[$urandom_range(0, 2)] | {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_req(a);
    end
    idle(10);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("bursts_drained", 32'(burst_q.size()), 32'd0);
    check("burst_count", 32'(n_hs), 32'(n_hs_exp));
`ifdef IMEM_PERF_CNT_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
